// File: rtl/sample_ctrl_pkg.sv
// sample_ctrl_pkg: shared state encoding and default sizing for the sample window controller
package sample_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;
  localparam int NUM_BITS_DEF = 10;
  localparam int DEFAULT_LEN_DEF = 1000;
endpackage

// File: rtl/sample_counter.sv
// sample_counter: window sample counter with clear, saturating increment and terminal flag
module sample_counter
  import sample_ctrl_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic [NUM_BITS-1:0] len,
  output logic [NUM_BITS-1:0] count,
  output logic                last
);
  // compare one bit wider so a full-scale length never wraps the sum
  assign last = ({1'b0, count} + 1'b1) == {1'b0, len};
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (inc && count != len) count <= count + 1'b1;
  end
endmodule

// File: rtl/sample_window_ctrl.sv
// sample_window_ctrl: sequences one acquisition window from start to acknowledged done
module sample_window_ctrl
  import sample_ctrl_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DEF,
  parameter int DEFAULT_LEN = DEFAULT_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [NUM_BITS-1:0] win_len,
  input  logic                sample_valid,
  input  logic                ack,
  output logic                busy,
  output logic                cnt_en,
  output logic [NUM_BITS-1:0] sample_count,
  output logic                window_done,
  output logic                overrun
);
  localparam logic [NUM_BITS-1:0] DEF_LEN = NUM_BITS'(DEFAULT_LEN);
  state_t state, next;
  logic [NUM_BITS-1:0] len_q;
  logic start_act, abort_act, rearm, clr, inc, last;
  assign start_act = start && state == IDLE;
  assign abort_act = abort && state != IDLE;
  assign rearm = state == DONE && ack && continuous && !abort;
  assign clr = start_act || abort_act || rearm;
  assign cnt_en = sample_valid && state == COUNT;
  assign inc = cnt_en && !abort;
  assign busy = state != IDLE;
  assign window_done = state == DONE;
  always_comb begin
    next = state;
    if (state == IDLE) next = start ? COUNT : IDLE;
    else if (state == COUNT) next = abort ? IDLE : (sample_valid && last) ? DONE : COUNT;
    else if (state == DONE) next = abort ? IDLE : ack ? (continuous ? COUNT : IDLE) : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state <= next;
      if (start_act || rearm) len_q <= (win_len == '0) ? DEF_LEN : win_len;
      if (start_act) overrun <= 1'b0;
      else if (state == DONE && sample_valid && !abort) overrun <= 1'b1;
    end
  end
  sample_counter #(.NUM_BITS(NUM_BITS)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(inc),
    .len(len_q),
    .count(sample_count),
    .last(last)
  );
endmodule

// File: tb/tb_sample_window_ctrl.sv
// tb_sample_window_ctrl: directed vector table plus long-window sequences
module tb_sample_window_ctrl;
  typedef struct {
    logic       rst, start, abort, cont;
    logic [9:0] len;
    logic       sv, ack;
    logic       busy, en;
    logic [9:0] cnt;
    logic       done, ovr;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [9:0] win_len = '0;
  logic sample_valid = 1'b0, ack = 1'b0;
  logic busy, cnt_en, window_done, overrun;
  logic [9:0] sample_count;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  sample_window_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .win_len(win_len), .sample_valid(sample_valid), .ack(ack), .busy(busy),
    .cnt_en(cnt_en), .sample_count(sample_count), .window_done(window_done), .overrun(overrun)
  );
  function automatic vec_t mk(logic r, s, a, c, logic [9:0] l, logic v, k,
                              logic b, e, logic [9:0] n, logic d, o);
    vec_t x;
    x.rst = r; x.start = s; x.abort = a; x.cont = c; x.len = l; x.sv = v; x.ack = k;
    x.busy = b; x.en = e; x.cnt = n; x.done = d; x.ovr = o;
    return x;
  endfunction
  task automatic drive(logic r, s, a, c, logic [9:0] l, logic v, k);
    rst = r; start = s; abort = a; continuous = c; win_len = l; sample_valid = v; ack = k;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [13:0] exp);
    logic [13:0] got;
    got = {busy, cnt_en, sample_count, window_done, overrun};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy/en/cnt/done/ovr=%b/%b/%0d/%b/%b want %b/%b/%0d/%b/%b",
               nm, got[13], got[12], got[11:2], got[1], got[0],
               exp[13], exp[12], exp[11:2], exp[1], exp[0]);
    end
  endtask
  initial begin
    // reset, then samples in IDLE are ignored
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,0));
    // window of 5 with gaps, then ack
    tbl.push_back(mk(0,1,0,0,5,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,5,1,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,5,0,0, 1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,5,1,0, 1,1,2,0,0));
    tbl.push_back(mk(0,0,0,0,5,1,0, 1,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,5,0,0, 1,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,5,1,0, 1,1,4,0,0));
    tbl.push_back(mk(0,0,0,0,5,1,0, 1,0,5,1,0));
    tbl.push_back(mk(0,0,0,0,5,0,0, 1,0,5,1,0));
    tbl.push_back(mk(0,0,0,0,5,0,1, 0,0,5,0,0));
    tbl.push_back(mk(0,0,0,0,5,0,0, 0,0,5,0,0));
    // abort together with the final sample
    tbl.push_back(mk(0,1,0,0,3,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,3,1,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,3,1,0, 1,1,2,0,0));
    tbl.push_back(mk(0,0,1,0,3,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,3,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,3,0,0, 0,0,0,0,0));
    // continuous re-arm, overrun persists until next start
    tbl.push_back(mk(0,1,0,1,2,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,1,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,2,1,0, 1,0,2,1,0));
    tbl.push_back(mk(0,0,0,1,2,1,0, 1,0,2,1,1));
    tbl.push_back(mk(0,0,0,1,2,0,1, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,1,2,1,0, 1,1,1,0,1));
    tbl.push_back(mk(0,0,0,1,2,1,0, 1,0,2,1,1));
    tbl.push_back(mk(0,0,0,0,2,1,1, 0,0,2,0,1));
    tbl.push_back(mk(0,1,0,0,2,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,2,0,0, 0,0,0,0,0));
    // length 1, abort in DONE
    tbl.push_back(mk(0,1,0,0,1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0, 1,0,1,1,0));
    tbl.push_back(mk(0,0,1,0,1,0,0, 0,0,0,0,0));
    // win_len change while busy is ignored
    tbl.push_back(mk(0,1,0,0,2,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0, 1,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,1,0,1, 0,0,2,0,0));
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].cont, tbl[i].len, tbl[i].sv, tbl[i].ack);
      chk($sformatf("vec%0d", i), {tbl[i].busy, tbl[i].en, tbl[i].cnt, tbl[i].done, tbl[i].ovr});
    end
    // default length 1000 when win_len is 0
    drive(0,1,0,0,0,0,0);
    chk("def_start", {1'b1, 1'b0, 10'd0, 1'b0, 1'b0});
    for (int i = 1; i <= 999; i++) drive(0,0,0,0,0,1,0);
    chk("def_999", {1'b1, 1'b1, 10'd999, 1'b0, 1'b0});
    drive(0,0,0,0,0,1,0);
    chk("def_1000", {1'b1, 1'b0, 10'd1000, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) drive(0,0,0,0,0,1,0);
    chk("def_overrun", {1'b1, 1'b0, 10'd1000, 1'b1, 1'b1});
    drive(0,0,0,0,0,0,1);
    chk("def_ack", {1'b0, 1'b0, 10'd1000, 1'b0, 1'b1});
    // full-scale 1023 window with a stray start mid-count
    drive(0,1,0,0,1023,0,0);
    chk("max_start", {1'b1, 1'b0, 10'd0, 1'b0, 1'b0});
    for (int i = 1; i <= 500; i++) drive(0,0,0,0,1023,1,0);
    drive(0,1,0,0,7,1,0);
    chk("max_start_ign", {1'b1, 1'b1, 10'd501, 1'b0, 1'b0});
    for (int i = 502; i <= 1022; i++) drive(0,0,0,0,1023,1,0);
    chk("max_1022", {1'b1, 1'b1, 10'd1022, 1'b0, 1'b0});
    drive(0,0,0,0,1023,1,0);
    chk("max_1023", {1'b1, 1'b0, 10'd1023, 1'b1, 1'b0});
    drive(0,0,0,0,1023,0,1);
    chk("max_ack", {1'b0, 1'b0, 10'd1023, 1'b0, 1'b0});
    // reset mid-count
    drive(0,1,0,0,9,0,0);
    for (int i = 0; i < 4; i++) drive(0,0,0,0,9,1,0);
    chk("pre_rst", {1'b1, 1'b1, 10'd4, 1'b0, 1'b0});
    drive(1,0,0,0,9,1,0);
    chk("mid_rst", {1'b0, 1'b0, 10'd0, 1'b0, 1'b0});
    drive(0,0,0,0,9,1,0);
    chk("post_rst", {1'b0, 1'b0, 10'd0, 1'b0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sample_window_ctrl.md
Name: sample_window_ctrl

Overview:
Sequences sample-window acquisition. On a start command it latches a programmable window length and counts qualified samples. It raises a done indication when the window fills and holds it until the downstream consumer acknowledges. It sits between the sample front-end (sample_valid strobes) and the block that drains each completed window.

Parameters:
NUM_BITS, 10, width of the window-length and sample counters
DEFAULT_LEN, 1000, window length used when win_len is 0 at start

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a window; honoured only in IDLE
abort  input  1  cancel the current window; honoured in COUNT and DONE
continuous  input  1  when high at ack, re-arm immediately without a new start
win_len  input  NUM_BITS  requested window length, sampled at start or at re-arm
sample_valid  input  1  one qualified sample this cycle
ack  input  1  consumer has taken the completed window; honoured only in DONE
busy  output  1  high in COUNT and DONE
cnt_en  output  1  sample_valid gated by state COUNT; combinational
sample_count  output  NUM_BITS  samples counted in the current or last window
window_done  output  1  level, high in DONE only
overrun  output  1  sticky; a sample arrived while in DONE

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, sample_count 0, latched length 0, window_done 0, busy 0, overrun 0.
- States: IDLE, COUNT, DONE. Encoding comes from the package enum.
- IDLE:
  - start=1 moves to COUNT next cycle.
  - Same edge: length register <= (win_len==0 ? DEFAULT_LEN : win_len), sample_count <= 0, overrun <= 0.
  - sample_valid is ignored in IDLE.
- COUNT:
  - Each sample_valid=1 increments sample_count by 1 on that edge.
  - If that increment makes sample_count equal the length register, the state is DONE on the same edge. window_done is high the cycle after the final sample.
  - The counter never exceeds the length register and never wraps.
  - start is ignored.
- DONE:
  - window_done=1; sample_count holds the final value.
  - sample_valid=1 sets overrun and does not change the count.
  - ack=1 with continuous=0: go to IDLE; sample_count holds its value.
  - ack=1 with continuous=1: go to COUNT; relatch length (same 0 rule), sample_count <= 0, overrun unchanged.
- abort (COUNT or DONE): next state IDLE, sample_count <= 0, window_done drops next cycle. No done is reported. abort in IDLE has no effect.
- Priority in the same cycle: rst > abort > ack > sample_valid.
  - abort together with the final sample: abort wins, no DONE.
  - ack together with sample_valid in DONE: overrun is set and ack is still honoured.
- Length 1: a single sample_valid moves COUNT to DONE.
- Maximum length 2^NUM_BITS-1 = 1023 must work.
- win_len changes while busy have no effect until the next latch point.
- Latency: start to busy is 1 cycle. Final sample to window_done is 1 cycle. ack to IDLE (busy low) is 1 cycle.

Decomposition:
- Package sample_ctrl_pkg: state enum (IDLE, COUNT, DONE), NUM_BITS_DEF=10, DEFAULT_LEN_DEF=1000.
- Sub-module sample_counter contains the NUM_BITS counter with enable, synchronous clear, load-compare against the length register and a terminal flag.
- The FSM and length register stay in sample_window_ctrl.

Test Plan:
1. rst held 2 cycles, then released -> all outputs 0, state IDLE. sample_valid pulses in IDLE -> sample_count stays 0.
2. start with win_len=5, then 5 sample_valid pulses with gaps -> busy high 1 cycle after start, sample_count 1..5, window_done high the cycle after the 5th sample. ack -> busy and window_done 0 the next cycle, sample_count holds 5.
3. start with win_len=0, then 1000 consecutive samples -> window_done after sample 1000, sample_count=1000. Further samples in DONE -> overrun=1 and the count stays 1000.
4. win_len=3, abort on the same cycle as the 3rd sample -> no window_done, IDLE next cycle, sample_count 0.
5. continuous=1, win_len=2, ack in DONE -> COUNT next cycle with sample_count 0. Two samples -> window_done again. overrun set earlier persists until the next start.
6. win_len=1023 full window -> window_done with sample_count=1023. A start pulse during COUNT is ignored. rst asserted mid-COUNT -> all outputs reset on the next edge.
